// File: rtl/rca2_bist_ctrl.sv
// rca2_bist_ctrl
//   Sequencer and fault collector for the duplicated 2-bit ripple-carry adder
//   double-fault test. Steps a 3-bit vector index into the LUT comparator
//   stage. Holds each index for a settle period, then samples the comparator's
//   mismatch vector once. Accumulates sticky error flags, then reports
//   pass/fail per adder copy.
//
// Parameters
//   NUM_VECTORS     vectors per run (1..8); index runs 0..NUM_VECTORS-1
//   SETTLE_CYCLES   cycles the index is held before comp is sampled (0..15)
//
// Ports
//   i_clk              in   1  clock, rising edge
//   i_rst              in   1  synchronous active-high reset
//   i_start            in   1  run request, honoured only in IDLE
//   i_comp             in   8  mismatch vector; copy A = {7,6,3,2}, copy B = {5,4,1,0}
//   o_count            out  3  test-vector index
//   o_busy             out  1  high while a run is in progress
//   o_done             out  1  one-cycle pulse when results become valid
//   o_err_map          out  8  sticky OR of every sampled comp in the run
//   o_fail_a           out  1  any copy-A mismatch seen
//   o_fail_b           out  1  any copy-B mismatch seen
//   o_double_fault     out  1  both copies failed
//   o_fail_count       out  4  number of vectors with a nonzero sample
//   o_first_fail_vec   out  3  index of the first failing vector, 0 if none

module rca2_bist_ctrl #(
  parameter int NUM_VECTORS   = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_comp,
  output logic [2:0] o_count,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_err_map,
  output logic       o_fail_a,
  output logic       o_fail_b,
  output logic       o_double_fault,
  output logic [3:0] o_fail_count,
  output logic [2:0] o_first_fail_vec
);

  localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_count;
  logic [3:0] r_settleCnt;
  logic [7:0] r_errMap;
  logic [3:0] r_failCount;
  logic [2:0] r_firstFailVec;

  logic w_sampleNow;
  logic w_lastVec;
  logic w_compFail;

  // comp is only trusted once the index has been stable for SETTLE cycles
  assign w_sampleNow = (r_state == RUN) && (r_settleCnt == SETTLE);
  assign w_lastVec   = (r_count == LAST_VEC);
  assign w_compFail  = |i_comp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (w_sampleNow && w_lastVec) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count        <= 3'd0;
      r_settleCnt    <= 4'd0;
      r_errMap       <= 8'd0;
      r_failCount    <= 4'd0;
      r_firstFailVec <= 3'd0;
    end else begin
      case (r_state)
        // Previous results stay visible in IDLE until the next run starts
        IDLE: begin
          if (i_start) begin
            r_count        <= 3'd0;
            r_settleCnt    <= 4'd0;
            r_errMap       <= 8'd0;
            r_failCount    <= 4'd0;
            r_firstFailVec <= 3'd0;
          end
        end
        RUN: begin
          if (!w_sampleNow) begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end else begin
            r_errMap    <= r_errMap | i_comp;
            r_settleCnt <= 4'd0;
            if (w_compFail) begin
              r_failCount <= r_failCount + 4'd1;
              if (r_failCount == 4'd0) r_firstFailVec <= r_count;
            end
            // Last index is held through DONE so it matches the final sample
            if (!w_lastVec) r_count <= r_count + 3'd1;
          end
        end
        DONE: begin
          r_count <= 3'd0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_count          = r_count;
  assign o_busy           = (r_state == RUN);
  assign o_done           = (r_state == DONE);
  assign o_err_map        = r_errMap;
  assign o_fail_a         = |{r_errMap[7], r_errMap[6], r_errMap[3], r_errMap[2]};
  assign o_fail_b         = |{r_errMap[5], r_errMap[4], r_errMap[1], r_errMap[0]};
  assign o_double_fault   = o_fail_a & o_fail_b;
  assign o_fail_count     = r_failCount;
  assign o_first_fail_vec = r_firstFailVec;

endmodule

// File: tb/tb_rca2_bist_ctrl.sv
// tb_rca2_bist_ctrl
//   Directed bench for rca2_bist_ctrl with default parameters (8 vectors,
//   1 settle cycle). Inputs change on the falling edge and outputs are
//   sampled there too. Cycle c counts rising edges after the start edge,
//   so cycle 1 is the first RUN cycle. Odd cycles are settle cycles,
//   even cycles sample vector (c-1)/2, and done is seen in cycle 17.

module tb_rca2_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] comp;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic [7:0] errMap;
  logic       failA;
  logic       failB;
  logic       doubleFault;
  logic [3:0] failCount;
  logic [2:0] firstFailVec;

  int testsRun    = 0;
  int testsFailed = 0;

  // comp value driven during the sampling cycle / settle cycle of each vector
  logic [7:0] sampleTab [8];
  logic [7:0] settleTab [8];

  rca2_bist_ctrl #(
    .NUM_VECTORS  (8),
    .SETTLE_CYCLES(1)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_comp          (comp),
    .o_count         (count),
    .o_busy          (busy),
    .o_done          (done),
    .o_err_map       (errMap),
    .o_fail_a        (failA),
    .o_fail_b        (failB),
    .o_double_fault  (doubleFault),
    .o_fail_count    (failCount),
    .o_first_fail_vec(firstFailVec)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream stalls the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Zero both comp tables so each scenario only sets what it needs
  task automatic clearTables();
    for (int i = 0; i < 8; i++) begin
      sampleTab[i] = 8'h00;
      settleTab[i] = 8'h00;
    end
  endtask

  // Reset for two edges, then every output must read zero
  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    comp  = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    testsRun++;
    if ({count, busy, done, errMap, failA, failB, doubleFault, failCount, firstFailVec} !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset: count=%0d busy=%b done=%b err_map=%h fa=%b fb=%b df=%b fc=%0d ffv=%0d, required all zero",
               count, busy, done, errMap, failA, failB, doubleFault, failCount, firstFailVec);
    end
    rst = 1'b0;
  endtask

  // Full run driven from the tables, checking the index every cycle and the
  // results at done; holdStart leaves start high after the done cycle
  task automatic runVectors(input string name, input logic holdStart,
                            input logic [7:0] expErr, input logic [3:0] expFc,
                            input logic [2:0] expFfv);
    logic expA;
    logic expB;
    expA = |(expErr & 8'hCC);
    expB = |(expErr & 8'h33);

    @(negedge clk);
    start = 1'b1;
    comp  = 8'h00;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      comp = ((c - 1) % 2 == 0) ? settleTab[(c - 1) / 2] : sampleTab[(c - 1) / 2];
      testsRun++;
      if (count !== 3'((c - 1) / 2) || busy !== 1'b1 || done !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL %s step c=%0d: count=%0d busy=%b done=%b, required count=%0d busy=1 done=0",
                 name, c, count, busy, done, (c - 1) / 2);
      end
      if (c == 1) begin
        testsRun++;
        if (errMap !== 8'h00 || failCount !== 4'd0 || firstFailVec !== 3'd0) begin
          testsFailed++;
          $display("[TB] FAIL %s clear-on-start: err_map=%h fc=%0d ffv=%0d, required 00/0/0",
                   name, errMap, failCount, firstFailVec);
        end
      end
    end

    // Cycle 17: done pulse with final results
    @(negedge clk);
    comp = 8'h00;
    testsRun++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 3'd7) begin
      testsFailed++;
      $display("[TB] FAIL %s done-timing: done=%b busy=%b count=%0d, required done=1 busy=0 count=7",
               name, done, busy, count);
    end
    testsRun++;
    if (errMap !== expErr || failA !== expA || failB !== expB || doubleFault !== (expA & expB)) begin
      testsFailed++;
      $display("[TB] FAIL %s flags: err_map=%h fa=%b fb=%b df=%b, required %h %b %b %b",
               name, errMap, failA, failB, doubleFault, expErr, expA, expB, expA & expB);
    end
    testsRun++;
    if (failCount !== expFc || firstFailVec !== expFfv) begin
      testsFailed++;
      $display("[TB] FAIL %s counts: fail_count=%0d first_fail_vec=%0d, required %0d %0d",
               name, failCount, firstFailVec, expFc, expFfv);
    end

    // Cycle 18: back in IDLE, done gone, index cleared, results held
    @(negedge clk);
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || errMap !== expErr || failCount !== expFc) begin
      testsFailed++;
      $display("[TB] FAIL %s idle-hold: done=%b busy=%b count=%0d err_map=%h fc=%0d, required 0 0 0 %h %0d",
               name, done, busy, count, errMap, failCount, expErr, expFc);
    end
  endtask

  task automatic test_clean_run();
    clearTables();
    runVectors("T1 clean", 1'b0, 8'h00, 4'd0, 3'd0);
  endtask

  task automatic test_single_fault();
    clearTables();
    sampleTab[3] = 8'h04;
    runVectors("T2 single", 1'b0, 8'h04, 4'd1, 3'd3);
  endtask

  task automatic test_double_fault();
    clearTables();
    sampleTab[2] = 8'h01;
    sampleTab[5] = 8'h80;
    runVectors("T3 double", 1'b0, 8'h81, 4'd2, 3'd2);
  endtask

  task automatic test_all_fail_then_rerun();
    for (int i = 0; i < 8; i++) begin
      sampleTab[i] = 8'hFF;
      settleTab[i] = 8'hFF;
    end
    runVectors("T4 all-fail", 1'b0, 8'hFF, 4'd8, 3'd0);
    clearTables();
    runVectors("T4 rerun", 1'b0, 8'h00, 4'd0, 3'd0);
  endtask

  task automatic test_settle_ignored();
    clearTables();
    settleTab[4] = 8'h10;
    runVectors("T5 settle", 1'b0, 8'h00, 4'd0, 3'd0);
  endtask

  // Restart attempt mid-run is ignored; reset mid-run aborts without done
  task automatic test_start_and_reset_mid_run();
    int doneSeen;
    clearTables();
    @(negedge clk);
    start = 1'b1;
    comp  = 8'h00;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = (c == 3);
      testsRun++;
      if (count !== 3'((c - 1) / 2) || busy !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL T6 no-restart c=%0d: count=%0d busy=%b, required count=%0d busy=1",
                 c, count, busy, (c - 1) / 2);
      end
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({count, busy, done, errMap, failA, failB, doubleFault, failCount, firstFailVec} !== 24'd0) begin
      testsFailed++;
      $display("[TB] FAIL T6 abort: count=%0d busy=%b done=%b err_map=%h fc=%0d ffv=%0d, required all zero",
               count, busy, done, errMap, failCount, firstFailVec);
    end
    rst = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) doneSeen++;
    end
    testsRun++;
    if (doneSeen != 0) begin
      testsFailed++;
      $display("[TB] FAIL T6 no-done: %0d cycles with done/busy high after abort, required 0", doneSeen);
    end
    runVectors("T6 restart", 1'b0, 8'h00, 4'd0, 3'd0);
  endtask

  // start held high re-arms from IDLE one cycle after DONE
  task automatic test_back_to_back();
    clearTables();
    sampleTab[7] = 8'h20;
    runVectors("B2B first", 1'b1, 8'h20, 4'd1, 3'd7);
    @(negedge clk);
    start = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || count !== 3'd0 || errMap !== 8'h00 || failCount !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL B2B rearm: busy=%b count=%0d err_map=%h fc=%0d, required 1 0 00 0",
               busy, count, errMap, failCount);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    comp  = 8'h00;
    clearTables();
    test_reset();
    test_clean_run();
    test_single_fault();
    test_double_fault();
    test_all_fail_then_rerun();
    test_settle_ignored();
    test_start_and_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
